// File: rtl/disparity_pkg.sv
// ============================================================================
// Module   : disparity_pkg
// Purpose  : Shared image geometry and writer types for the disparity pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

package disparity_pkg;

  localparam int IMG_W        = 320;
  localparam int IMG_H        = 240;
  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int DISP_W       = 6;
  localparam int ADDR_W       = 17;
  localparam int FIFO_DEPTH   = 16;
  localparam int FRAME_PIXELS = IMG_W * IMG_H;
  localparam int LAST_ADDR    = FRAME_PIXELS - 1;

  typedef enum logic [0:0] {
    WR_IDLE  = 1'b0,
    WR_WRITE = 1'b1
  } wr_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO; the head entry is always visible on pop_data.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full     = (level_q == (PTR_W+1)'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves on the same edge.
  always_comb begin
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (PTR_W+1)'(1);
      2'b01:   level_d = level_q - (PTR_W+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/disparity_writer.sv
// ============================================================================
// Module   : disparity_writer
// Purpose  : Converts correlator results to grayscale pixels and writes them
//            to frame memory through a decoupling FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module disparity_writer
  import disparity_pkg::*;
#(
  parameter int IMG_W      = disparity_pkg::IMG_W,
  parameter int IMG_H      = disparity_pkg::IMG_H,
  parameter int X_W        = disparity_pkg::X_W,
  parameter int Y_W        = disparity_pkg::Y_W,
  parameter int DISP_W     = disparity_pkg::DISP_W,
  parameter int ADDR_W     = disparity_pkg::ADDR_W,
  parameter int FIFO_DEPTH = disparity_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DISP_W-1:0]             disparity,
  input  logic                          disparity_val,
  input  logic [X_W-1:0]                pixel_x,
  input  logic [Y_W-1:0]                pixel_y,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [7:0]                    mem_wrdata,
  output logic                          mem_write,
  input  logic                          mem_waitrequest,
  input  logic                          clear_overflow,
  output logic                          overflow,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int                ENT_W  = ADDR_W + 8;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(IMG_W * IMG_H - 1);

  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
  logic [7:0]        s1_pix_q,   s1_pix_d;
  logic [7:0]        pix_w;
  logic              in_range;

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wrdata_q, mem_wrdata_d;
  logic              mem_write_q, mem_write_d;
  logic              frame_done_q, frame_done_d;
  logic              overflow_q, overflow_d;

  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic              accept;
  logic              drop;

  // Grayscale expansion repeats the top disparity bits into the low byte.
  if (DISP_W < 8) begin : g_pix_rep
    assign pix_w = {disparity, disparity[DISP_W-1 -: 8-DISP_W]};
  end else begin : g_pix_trunc
    assign pix_w = disparity[DISP_W-1 -: 8];
  end

  always_comb begin
    in_range   = (32'(pixel_x) < 32'(IMG_W)) && (32'(pixel_y) < 32'(IMG_H));
    s1_valid_d = disparity_val && in_range;
    s1_addr_d  = s1_addr_q;
    s1_pix_d   = s1_pix_q;
    if (s1_valid_d) begin
      s1_addr_d = ADDR_W'(32'(pixel_y) * 32'(IMG_W) + 32'(pixel_x));
      s1_pix_d  = pix_w;
    end
  end

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid_q),
    .push_data ({s1_addr_q, s1_pix_q}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign accept = mem_write_q && !mem_waitrequest;
  assign drop   = s1_valid_q && fifo_full && !fifo_pop;

  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wrdata_d = mem_wrdata_q;
    mem_write_d  = mem_write_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          mem_addr_d   = fifo_head[ENT_W-1:8];
          mem_wrdata_d = fifo_head[7:0];
          mem_write_d  = 1'b1;
          state_d      = WR_WRITE;
        end
      end
      WR_WRITE: begin
        if (accept) begin
          frame_done_d = (mem_addr_q == LAST_A);
          if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            mem_addr_d   = fifo_head[ENT_W-1:8];
            mem_wrdata_d = fifo_head[7:0];
          end else begin
            mem_write_d  = 1'b0;
            state_d      = WR_IDLE;
          end
        end
      end
      default: state_d = WR_IDLE;
    endcase
    overflow_d = drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s1_pix_q     <= '0;
      state_q      <= WR_IDLE;
      mem_addr_q   <= '0;
      mem_wrdata_q <= '0;
      mem_write_q  <= 1'b0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s1_pix_q     <= s1_pix_d;
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_wrdata_q <= mem_wrdata_d;
      mem_write_q  <= mem_write_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_wrdata = mem_wrdata_q;
  assign mem_write  = mem_write_q;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_disparity_writer.sv
// ============================================================================
// Module   : tb_disparity_writer
// Purpose  : Directed and randomized self-checking bench for disparity_writer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_disparity_writer;
  import disparity_pkg::*;

  logic                            clk = 1'b0;
  logic                            reset = 1'b1;
  logic [DISP_W-1:0]               disparity = '0;
  logic                            disparity_val = 1'b0;
  logic [X_W-1:0]                  pixel_x = '0;
  logic [Y_W-1:0]                  pixel_y = '0;
  logic [ADDR_W-1:0]               mem_addr;
  logic [7:0]                      mem_wrdata;
  logic                            mem_write;
  logic                            mem_waitrequest = 1'b0;
  logic                            clear_overflow = 1'b0;
  logic                            overflow;
  logic                            frame_done;
  logic [$clog2(FIFO_DEPTH):0]     fifo_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_cnt = 0;
  int peak;

  logic [ADDR_W-1:0] got_addr[$];
  logic [7:0]        got_data[$];
  int                got_cyc[$];
  int                exp_addr[$];
  int                exp_data[$];

  disparity_writer dut (
    .clk             (clk),
    .reset           (reset),
    .disparity       (disparity),
    .disparity_val   (disparity_val),
    .pixel_x         (pixel_x),
    .pixel_y         (pixel_y),
    .mem_addr        (mem_addr),
    .mem_wrdata      (mem_wrdata),
    .mem_write       (mem_write),
    .mem_waitrequest (mem_waitrequest),
    .clear_overflow  (clear_overflow),
    .overflow        (overflow),
    .frame_done      (frame_done),
    .fifo_level      (fifo_level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs are stable between the falling edge and the next rising edge,
  // so a request seen here without a stall is accepted on that rising edge.
  always @(negedge clk) begin
    if (!reset && mem_write && !mem_waitrequest) begin
      got_addr.push_back(mem_addr);
      got_data.push_back(mem_wrdata);
      got_cyc.push_back(cyc);
    end
    if (!reset && frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int x, input int y, input int d);
    disparity_val = 1'b1;
    pixel_x       = X_W'(x);
    pixel_y       = Y_W'(y);
    disparity     = DISP_W'(d);
    if (x < IMG_W && y < IMG_H) begin
      exp_addr.push_back(y * IMG_W + x);
      exp_data.push_back((d * 4 + d / 16) % 256);
    end
    tick();
    disparity_val = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int i = 0; i < budget && got_addr.size() < n; i++) tick();
  endtask

  task automatic compare(input string tag);
    int n;
    chk({tag, " count"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, " addr"}, got_addr[i], exp_addr[i]);
      chk({tag, " data"}, got_data[i], exp_data[i]);
    end
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    exp_addr.delete();
    exp_data.delete();
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst mem_write", mem_write, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wrdata", mem_wrdata, 0);
    chk("rst overflow", overflow, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst fifo_level", fifo_level, 0);
    reset = 1'b0;
    tick();

    // Single result, no stall: request appears after the third edge
    send(5, 2, 63);
    chk("t1 wr e1", mem_write, 0);
    tick();
    chk("t1 lvl e2", fifo_level, 1);
    chk("t1 wr e2", mem_write, 0);
    tick();
    chk("t1 wr e3", mem_write, 1);
    chk("t1 addr", mem_addr, 645);
    chk("t1 data", mem_wrdata, 8'hFF);
    chk("t1 lvl e3", fifo_level, 0);
    tick();
    chk("t1 wr e4", mem_write, 0);
    compare("t1");

    // Stall with four queued results
    mem_waitrequest = 1'b1;
    peak = 0;
    for (int i = 0; i < 4; i++) begin
      send(i, 0, i * 16);
      if (fifo_level > peak) peak = fifo_level;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (fifo_level > peak) peak = fifo_level;
    end
    chk("t2 held wr", mem_write, 1);
    chk("t2 held addr", mem_addr, 0);
    chk("t2 held data", mem_wrdata, 0);
    chk("t2 peak", peak, 3);
    mem_waitrequest = 1'b0;
    wait_writes(4, 20);
    tick();
    if (got_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("t2 b2b", got_cyc[i] - got_cyc[i-1], 1);
    end
    compare("t2");

    // Overflow: one held in the write register, sixteen buffered, rest lost
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 20; i++) send(i, 1, i);
    while (exp_addr.size() > 17) begin
      void'(exp_addr.pop_back());
      void'(exp_data.pop_back());
    end
    tick();
    tick();
    chk("t3 lvl full", fifo_level, FIFO_DEPTH);
    chk("t3 ovf set", overflow, 1);
    mem_waitrequest = 1'b0;
    wait_writes(17, 60);
    for (int i = 0; i < 5; i++) tick();
    compare("t3");
    chk("t3 ovf sticky", overflow, 1);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("t3 ovf clr", overflow, 0);

    // Frame end pulse and out-of-range discard
    fd_cnt = 0;
    send(IMG_W - 1, IMG_H - 1, 10);
    tick();
    tick();
    chk("t4 wr", mem_write, 1);
    chk("t4 addr", mem_addr, LAST_ADDR);
    tick();
    chk("t4 fd hi", frame_done, 1);
    tick();
    chk("t4 fd lo", frame_done, 0);
    send(IMG_W, 0, 5);
    for (int i = 0; i < 5; i++) tick();
    chk("t4 fd count", fd_cnt, 1);
    chk("t4 ovf", overflow, 0);
    compare("t4");

    // Asynchronous reset while a write is pending
    mem_waitrequest = 1'b1;
    for (int i = 0; i < 6; i++) send(10 + i, 3, i);
    tick();
    tick();
    chk("t5 pre lvl", fifo_level, 5);
    chk("t5 pre wr", mem_write, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5 async wr", mem_write, 0);
    chk("t5 async lvl", fifo_level, 0);
    chk("t5 async ovf", overflow, 0);
    tick();
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    exp_addr.delete();
    exp_data.delete();
    got_addr.delete();
    got_data.delete();
    got_cyc.delete();
    for (int i = 0; i < 10; i++) tick();
    chk("t5 lvl after", fifo_level, 0);
    compare("t5");

    // Full-rate random stream with random stalls, kept clear of overflow
    for (int i = 0; i < 64; i++) begin
      mem_waitrequest = (fifo_level >= 12) ? 1'b0 : 1'($urandom_range(0, 1));
      send($urandom_range(0, IMG_W - 1), $urandom_range(0, IMG_H - 1),
           $urandom_range(0, 63));
    end
    for (int i = 0; i < 400 && got_addr.size() < 64; i++) begin
      mem_waitrequest = 1'($urandom_range(0, 1));
      tick();
    end
    mem_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("t6 ovf", overflow, 0);
    chk("t6 lvl", fifo_level, 0);
    compare("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/disparity_writer.md
Name: disparity_writer

Overview:
- Downstream consumer of the `correlate` stage.
- Takes the `disparity` / `disparity_val` / `pixel_x` / `pixel_y` stream and converts each result to an 8-bit grayscale pixel at linear address y*IMG_W + x.
- Buffers results in a small FIFO and writes them to frame memory over a valid/waitrequest write port, so memory stalls never back-pressure the correlator.
- Flags the last pixel of a frame and records dropped results.

Parameters:
- IMG_W, 320, image width in pixels
- IMG_H, 240, image height in pixels
- X_W, 9, width of pixel_x
- Y_W, 8, width of pixel_y
- DISP_W, 6, width of disparity
- ADDR_W, 17, width of mem_addr; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- FIFO_DEPTH, 16, entry count; power of two, >= 4

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- disparity  in  DISP_W  disparity result from correlate
- disparity_val  in  1  one-cycle qualifier for disparity/pixel_x/pixel_y
- pixel_x  in  X_W  column of the result
- pixel_y  in  Y_W  row of the result
- mem_addr  out  ADDR_W  write address
- mem_wrdata  out  8  grayscale pixel
- mem_write  out  1  write request; held until accepted
- mem_waitrequest  in  1  memory stall; a write is accepted on an edge where mem_write=1 and mem_waitrequest=0
- clear_overflow  in  1  clears the overflow flag
- overflow  out  1  sticky: at least one result was dropped
- frame_done  out  1  one-cycle pulse when the write to address IMG_W*IMG_H-1 is accepted
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, synchronous-edge release):
  - All outputs go to 0.
  - FIFO pointers and level go to 0.
  - The input stage register is invalidated.
  - A pending write is abandoned; there is no partial-state carry-over.
- Stage 1 (registered, edge k, when disparity_val=1):
  - Results with pixel_x >= IMG_W or pixel_y >= IMG_H are discarded silently (no FIFO push, overflow unaffected).
  - Otherwise register addr = pixel_y*IMG_W + pixel_x, truncated to ADDR_W.
  - Register pix = {disparity, disparity[DISP_W-1 -: 8-DISP_W]}, i.e. MSB replication to 8 bits (63 -> 0xFF, 0 -> 0x00, 32 -> 0x82).
- Stage 2 (edge k+1): the stage-1 entry is pushed into the FIFO.
  - If the FIFO is full and no pop occurs on the same edge, the entry is dropped and overflow is set.
  - Push and pop on the same edge while full: the push is accepted and the level is unchanged.
  - Push and pop on the same edge while empty: not a bypass; the pop needs a non-empty FIFO.
- Writer FSM:
  - IDLE:
    - If the FIFO is non-empty, pop the head into the mem_addr/mem_wrdata registers, set mem_write=1 and go to WRITE.
    - Minimum latency: disparity_val at cycle k gives mem_write=1 in the cycle after edge k+2.
  - WRITE:
    - mem_addr, mem_wrdata and mem_write stay stable while mem_waitrequest=1.
    - On an accepting edge, if the FIFO is non-empty, pop the next entry on the same edge and stay in WRITE (back-to-back, 1 write/cycle).
    - If the FIFO is empty, clear mem_write and go to IDLE.
- frame_done:
  - Registered; high for exactly one cycle after the accepting edge whose mem_addr == IMG_W*IMG_H-1.
  - Not gated by frame ordering or duplicate addresses.
- overflow:
  - Set on a drop; cleared by clear_overflow.
  - A drop on the same edge as clear_overflow wins (overflow=1).
- fifo_level is a registered count and equals the number of stored entries (0..FIFO_DEPTH).
- Arithmetic: the multiply uses the constant IMG_W; synthesis is free to use shift-add. There is no rounding.

Decomposition:
- Package disparity_pkg:
  - IMG_W, IMG_H, X_W, Y_W, DISP_W, and the derived constants FRAME_PIXELS and LAST_ADDR.
  - Shared with correlate and the VGA reader.
- One sub-module, sync_fifo:
  - Parameterised width/depth.
  - Synchronous read with head-register semantics, full/empty/level outputs, async active-high reset.
  - Entry width ADDR_W+8.

Test Plan:
1. Single result with mem_waitrequest=0: x=5, y=2, disparity=63 at cycle 0 -> mem_write=1 in cycle 3 with addr 645, data 0xFF, for one cycle; fifo_level returns to 0.
2. Stall: 4 consecutive results (x=0..3, y=0, disparity=0,16,32,48), mem_waitrequest=1 for 10 cycles -> mem_write held on addr 0, data 0x00; after release the writes are 0x00,0x41,0x82,0xC3 on consecutive cycles; peak fifo_level 3.
3. Overflow: mem_waitrequest=1 while 20 results arrive on consecutive cycles -> fifo_level saturates at 16; overflow=1; after release exactly 17 writes occur (16 in the FIFO plus the held one, per the pop timing); clear_overflow drops it to 0.
4. Frame end: result x=319, y=239 -> a write to addr 76799, then frame_done high for exactly 1 cycle; out-of-range x=320 is never written and leaves overflow=0.
5. Reset mid-operation: assert reset while in WRITE with 5 queued entries -> mem_write, fifo_level and overflow are 0 immediately (asynchronous); after release no stale write appears.
6. Full-rate stream of 64 results with random 0/1 mem_waitrequest -> a scoreboard confirms every address/data pair is written in order exactly once, with no drops while the level stays below 16.
